// File: rtl/matrix_uart_formatter.sv
// Renders one or more signed matrices from storage as ASCII text (space-separated, CRLF rows,
// optional 1-based matrix ID headers) over a valid/ready byte stream toward a shared UART TX.
module matrix_uart_formatter #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8,
    parameter int DIM_W  = 4,
    parameter int CNT_W  = 3,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              mode,
    input  logic [DIM_W-1:0]  dim_m,
    input  logic [DIM_W-1:0]  dim_n,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  mat_cnt,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int ND   = DATA_W / 3 + 1;
    localparam int BW   = 4 * ND;
    localparam int DIGW = $clog2(ND);
    localparam int STW  = $clog2(DATA_W);
    localparam int LATW = 3;

    typedef enum logic [3:0] {
        IDLE, CHECK, HDR, RD_REQ, RD_WAIT, CONV, EMIT, SEP, DONE
    } state_t;

    state_t state_q, state_d;

    logic              mode_q, err_q, hdr_q, lf_q, started_q, sign_pend_q;
    logic [DIM_W-1:0]  m_q, n_q, r_q, c_q;
    logic [CNT_W-1:0]  cnt_q, k_q;
    logic [ADDR_W-1:0] addr_q;
    logic [LATW-1:0]   lat_q;
    logic [STW-1:0]    step_q;
    logic [DIGW-1:0]   dig_q;
    logic [DATA_W-1:0] bin_q, mag;
    logic [BW-1:0]     bcd_q, bcd_adj;
    logic [3:0]        cur_digit;
    logic              degenerate, last_col, last_row, last_mat;
    logic              xfer, lead_zero, need_crlf, sep_adv;

    assign degenerate = (m_q == '0) || (n_q == '0) || (mode_q && (cnt_q == '0));
    assign last_col   = (c_q == n_q - DIM_W'(1));
    assign last_row   = (r_q == m_q - DIM_W'(1));
    assign last_mat   = (k_q == cnt_q - CNT_W'(1));
    assign xfer       = tx_valid && tx_ready;
    assign cur_digit  = bcd_q[{dig_q, 2'b00} +: 4];
    assign lead_zero  = !started_q && (cur_digit == 4'd0) && (dig_q != '0);
    assign need_crlf  = hdr_q || last_col;
    assign sep_adv    = (state_q == SEP) && xfer && !(need_crlf && !lf_q);
    assign mag        = rd_data[DATA_W-1] ? (~rd_data + DATA_W'(1)) : rd_data;

    // Double-dabble correction: every BCD digit of 5 or more gets +3 before the shift.
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < ND; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        rd_en    = 1'b0;
        rd_addr  = '0;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        busy     = (state_q != IDLE);
        done     = 1'b0;
        err      = 1'b0;
        case (state_q)
            IDLE:    if (start) state_d = CHECK;
            CHECK: begin
                if (degenerate)  state_d = DONE;
                else if (mode_q) state_d = HDR;
                else             state_d = RD_REQ;
            end
            HDR:     state_d = CONV;
            RD_REQ: begin
                rd_en   = 1'b1;
                rd_addr = addr_q;
                state_d = RD_WAIT;
            end
            RD_WAIT: if (lat_q == LATW'(RD_LAT)) state_d = CONV;
            CONV:    if (step_q == STW'(DATA_W - 1)) state_d = EMIT;
            EMIT: begin
                if (sign_pend_q) begin
                    tx_valid = 1'b1;
                    tx_data  = 8'h2D;
                end else if (!lead_zero) begin
                    tx_valid = 1'b1;
                    tx_data  = 8'h30 + {4'h0, cur_digit};
                    if (xfer && (dig_q == '0)) state_d = SEP;
                end
            end
            SEP: begin
                tx_valid = 1'b1;
                tx_data  = !need_crlf ? 8'h20 : (lf_q ? 8'h0A : 8'h0D);
                if (sep_adv) begin
                    if (hdr_q || !last_col || !last_row) state_d = RD_REQ;
                    else if (!last_mat)                  state_d = mode_q ? HDR : RD_REQ;
                    else                                 state_d = DONE;
                end
            end
            DONE: begin
                done    = 1'b1;
                err     = err_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath: request latching, element pointer, BCD conversion and byte sequencing.
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q <= 1'b0; err_q <= 1'b0; hdr_q <= 1'b0; lf_q <= 1'b0;
            started_q <= 1'b0; sign_pend_q <= 1'b0;
            m_q <= '0; n_q <= '0; r_q <= '0; c_q <= '0; cnt_q <= '0; k_q <= '0;
            addr_q <= '0; lat_q <= '0; step_q <= '0; dig_q <= '0;
            bin_q <= '0; bcd_q <= '0;
        end else begin
            case (state_q)
                IDLE: if (start) begin
                    mode_q <= mode;
                    m_q    <= dim_m;
                    n_q    <= dim_n;
                    addr_q <= base_addr;
                    cnt_q  <= mode ? mat_cnt : CNT_W'(1);
                    k_q    <= '0;
                    r_q    <= '0;
                    c_q    <= '0;
                    err_q  <= 1'b0;
                    hdr_q  <= 1'b0;
                    lf_q   <= 1'b0;
                end
                CHECK: err_q <= degenerate;
                HDR: begin
                    hdr_q       <= 1'b1;
                    bin_q       <= DATA_W'(k_q) + DATA_W'(1);
                    sign_pend_q <= 1'b0;
                    bcd_q       <= '0;
                    step_q      <= '0;
                    dig_q       <= DIGW'(ND - 1);
                    started_q   <= 1'b0;
                end
                RD_REQ: lat_q <= LATW'(1);
                RD_WAIT: begin
                    lat_q <= lat_q + LATW'(1);
                    if (lat_q == LATW'(RD_LAT)) begin
                        bin_q       <= mag;
                        sign_pend_q <= rd_data[DATA_W-1];
                        bcd_q       <= '0;
                        step_q      <= '0;
                        dig_q       <= DIGW'(ND - 1);
                        started_q   <= 1'b0;
                    end
                end
                CONV: begin
                    {bcd_q, bin_q} <= {bcd_adj[BW-2:0], bin_q, 1'b0};
                    step_q         <= step_q + STW'(1);
                end
                EMIT: begin
                    if (sign_pend_q) begin
                        if (xfer) sign_pend_q <= 1'b0;
                    end else if (lead_zero) begin
                        dig_q <= dig_q - DIGW'(1);
                    end else if (xfer) begin
                        started_q <= 1'b1;
                        if (dig_q != '0) dig_q <= dig_q - DIGW'(1);
                    end
                end
                SEP: begin
                    if (xfer && need_crlf && !lf_q) lf_q <= 1'b1;
                    if (sep_adv) begin
                        lf_q <= 1'b0;
                        if (hdr_q) begin
                            hdr_q <= 1'b0;
                        end else begin
                            addr_q <= addr_q + ADDR_W'(1);
                            if (!last_col) begin
                                c_q <= c_q + DIM_W'(1);
                            end else begin
                                c_q <= '0;
                                if (!last_row) begin
                                    r_q <= r_q + DIM_W'(1);
                                end else begin
                                    r_q <= '0;
                                    k_q <= k_q + CNT_W'(1);
                                end
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
